// File: rtl/camera_sensor_emulator.sv
// Emulates a parallel-interface image sensor: frame_valid / line_valid / pixel data
// timing with selectable test patterns, looped back into the camera controller.
module camera_sensor_emulator #(
    parameter int DATA_WIDTH  = 12,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int FV_LEAD     = 4,
    parameter int H_BLANK     = 16,
    parameter int FV_TRAIL    = 4,
    parameter int V_BLANK     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cam_reset_n,
    input  logic                  cam_trigger,
    input  logic                  continuous,
    input  logic [1:0]            pattern,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  frame_valid,
    output logic                  line_valid,
    output logic                  busy,
    output logic [15:0]           frame_count
);

    localparam int COL_W = (ACTIVE_COLS > 1) ? $clog2(ACTIVE_COLS) : 1;
    localparam int ROW_W = (ACTIVE_ROWS > 1) ? $clog2(ACTIVE_ROWS) : 1;
    localparam int MAX_A = (FV_LEAD > H_BLANK) ? FV_LEAD : H_BLANK;
    localparam int MAX_B = (FV_TRAIL > V_BLANK) ? FV_TRAIL : V_BLANK;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {IDLE, LEAD, LINE, HBLANK, TRAIL, VBLANK} state_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [COL_W-1:0]      col, col_n;
    logic [ROW_W-1:0]      row, row_n;
    logic [DATA_WIDTH-1:0] pix, pix_n;
    logic [1:0]            pat, pat_n;
    logic                  frame_done;
    logic                  start;

    logic [DATA_WIDTH-1:0] data_n;
    logic                  fv_n, lv_n, busy_n;
    logic [31:0]           row_ext, col_ext;

    assign start = cam_trigger | continuous;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            col   <= '0;
            row   <= '0;
            pix   <= '0;
            pat   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            col   <= col_n;
            row   <= row_n;
            pix   <= pix_n;
            pat   <= pat_n;
        end
    end

    // cnt measures time spent in the timed states; col/row/pix describe the pixel on the bus.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        col_n      = col;
        row_n      = row;
        pix_n      = pix;
        pat_n      = pat;
        frame_done = 1'b0;
        if (!cam_reset_n) begin
            state_n = IDLE;
            cnt_n   = '0;
            col_n   = '0;
            row_n   = '0;
            pix_n   = '0;
            pat_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = LEAD;
                        cnt_n   = '0;
                        col_n   = '0;
                        row_n   = '0;
                        pix_n   = '0;
                        pat_n   = pattern;
                    end
                end
                LEAD: begin
                    if (cnt == CNT_W'(FV_LEAD - 1)) begin
                        state_n = LINE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                LINE: begin
                    pix_n = pix + 1'b1;
                    if (col == COL_W'(ACTIVE_COLS - 1)) begin
                        col_n = '0;
                        cnt_n = '0;
                        if (row == ROW_W'(ACTIVE_ROWS - 1)) begin
                            state_n = TRAIL;
                        end else begin
                            state_n = HBLANK;
                            row_n   = row + 1'b1;
                        end
                    end else begin
                        col_n = col + 1'b1;
                    end
                end
                HBLANK: begin
                    if (cnt == CNT_W'(H_BLANK - 1)) begin
                        state_n = LINE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                TRAIL: begin
                    if (cnt == CNT_W'(FV_TRAIL - 1)) begin
                        state_n    = VBLANK;
                        cnt_n      = '0;
                        frame_done = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                VBLANK: begin
                    if (cnt == CNT_W'(V_BLANK - 1)) begin
                        cnt_n = '0;
                        if (start) begin
                            state_n = LEAD;
                            col_n   = '0;
                            row_n   = '0;
                            pix_n   = '0;
                            pat_n   = pattern;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered bus lines up with the state.
    always_comb begin
        row_ext = 32'(row_n);
        col_ext = 32'(col_n);
        fv_n    = (state_n == LEAD) || (state_n == LINE) ||
                  (state_n == HBLANK) || (state_n == TRAIL);
        lv_n    = (state_n == LINE);
        busy_n  = (state_n != IDLE);
        data_n  = '0;
        if (lv_n) begin
            case (pat_n)
                2'd0:    data_n = pix_n;
                2'd1:    data_n = DATA_WIDTH'(col_n);
                2'd2:    data_n = DATA_WIDTH'(row_n) + DATA_WIDTH'(col_n);
                default: data_n = (row_ext[3] ^ col_ext[3]) ? '1 : '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data        <= '0;
            frame_valid <= 1'b0;
            line_valid  <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            data        <= data_n;
            frame_valid <= fv_n;
            line_valid  <= lv_n;
            busy        <= busy_n;
            if (!cam_reset_n) begin
                frame_count <= '0;
            end else if (frame_done) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_camera_sensor_emulator.sv
// Randomized bench for camera_sensor_emulator: a per-cycle expected trace is built
// from the frame timing rules and compared against the sensor outputs.
module tb_camera_sensor_emulator;

    localparam int DW   = 12;
    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int LEAD = 2;
    localparam int HB   = 2;
    localparam int TR   = 1;
    localparam int VB   = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cam_reset_n;
    logic          cam_trigger;
    logic          continuous;
    logic [1:0]    pattern;
    logic [DW-1:0] data;
    logic          frame_valid;
    logic          line_valid;
    logic          busy;
    logic [15:0]   frame_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_fc = 16'd0;

    typedef struct packed {
        logic          fv;
        logic          lv;
        logic          busy;
        logic [DW-1:0] data;
        logic [15:0]   fc;
    } obs_t;

    obs_t exp_q[$];

    always #5 clk = ~clk;

    camera_sensor_emulator #(
        .DATA_WIDTH (DW),
        .ACTIVE_COLS(COLS),
        .ACTIVE_ROWS(ROWS),
        .FV_LEAD    (LEAD),
        .H_BLANK    (HB),
        .FV_TRAIL   (TR),
        .V_BLANK    (VB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cam_reset_n(cam_reset_n),
        .cam_trigger(cam_trigger),
        .continuous (continuous),
        .pattern    (pattern),
        .data       (data),
        .frame_valid(frame_valid),
        .line_valid (line_valid),
        .busy       (busy),
        .frame_count(frame_count)
    );

    function automatic obs_t sample_now();
        obs_t o;
        o.fv   = frame_valid;
        o.lv   = line_valid;
        o.busy = busy;
        o.data = data;
        o.fc   = frame_count;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("fv=%b lv=%b busy=%b data=%0d fc=%0d", o.fv, o.lv, o.busy, o.data, o.fc);
    endfunction

    function automatic logic [DW-1:0] ref_pixel(input int p, input int r, input int c);
        case (p)
            0:       return DW'(r * COLS + c);
            1:       return DW'(c);
            2:       return DW'(r + c);
            default: return ((((r >> 3) ^ (c >> 3)) & 1) != 0) ? {DW{1'b1}} : {DW{1'b0}};
        endcase
    endfunction

    task automatic push(input logic fv, input logic lv, input logic b,
                        input logic [DW-1:0] d, input logic [15:0] fc, input int n);
        obs_t e;
        e.fv = fv; e.lv = lv; e.busy = b; e.data = d; e.fc = fc;
        repeat (n) exp_q.push_back(e);
    endtask

    // One whole frame as seen on the bus, followed by its vertical blanking.
    task automatic build_frame(input int p, input bit go_idle);
        push(1, 0, 1, '0, model_fc, LEAD);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) push(1, 1, 1, ref_pixel(p, r, c), model_fc, 1);
            if (r < ROWS - 1) push(1, 0, 1, '0, model_fc, HB);
        end
        push(1, 0, 1, '0, model_fc, TR);
        model_fc = model_fc + 16'd1;
        push(0, 0, 1, '0, model_fc, VB);
        if (go_idle) push(0, 0, 0, '0, model_fc, 1);
    endtask

    task automatic tick(output obs_t o);
        @(posedge clk);
        #1;
        o = sample_now();
    endtask

    task automatic test_reset();
        obs_t o;
        reset_n = 1'b0;
        repeat (2) tick(o);
        checks++;
        if (o !== obs_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_state: got %s, expected all zero", fmt(o));
        end
        reset_n = 1'b1;
        tick(o);
        checks++;
        if (o !== obs_t'(0)) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %s, expected all zero", fmt(o));
        end
    endtask

    task automatic test_single_frame(input int p, input string name);
        obs_t o, e;
        int   i = 0;
        pattern     = 2'(p);
        cam_trigger = 1'b1;
        build_frame(p, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick(o);
            if (i == 0) cam_trigger = 1'b0;
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got %s, expected %s", name, i, fmt(o), fmt(e));
            end
            i++;
        end
    endtask

    task automatic test_continuous();
        obs_t o, e;
        int   p = $urandom_range(0, 3);
        int   nxt;
        pattern    = 2'(p);
        continuous = 1'b1;
        for (int f = 0; f < 3; f++) begin
            int i = 0;
            build_frame(p, f == 2);
            nxt = $urandom_range(0, 3);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tick(o);
                if (i == 3) pattern = 2'(nxt);
                if (f == 2 && i == 5) continuous = 1'b0;
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL continuous frame %0d cycle %0d: got %s, expected %s",
                             f, i, fmt(o), fmt(e));
                end
                i++;
            end
            p = nxt;
        end
    endtask

    task automatic test_pattern_change();
        obs_t o, e;
        for (int f = 0; f < 2; f++) begin
            int i = 0;
            if (f == 0) pattern = 2'd0;
            cam_trigger = 1'b1;
            build_frame(f, 1);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tick(o);
                if (i == 0) cam_trigger = 1'b0;
                if (f == 0 && i == 3) pattern = 2'd1;
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL pattern_change frame %0d cycle %0d: got %s, expected %s",
                             f, i, fmt(o), fmt(e));
                end
                i++;
            end
        end
    endtask

    task automatic test_cam_reset();
        obs_t o, e;
        pattern     = 2'd0;
        cam_trigger = 1'b1;
        build_frame(0, 1);
        // Run into the first pixel of the second line, then yank the sensor reset.
        for (int i = 0; i < LEAD + COLS + HB + 1; i++) begin
            e = exp_q.pop_front();
            tick(o);
            if (i == 0) cam_trigger = 1'b0;
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL cam_reset_prefix cycle %0d: got %s, expected %s", i, fmt(o), fmt(e));
            end
        end
        exp_q.delete();
        cam_reset_n = 1'b0;
        cam_trigger = 1'b1;
        model_fc    = 16'd0;
        for (int i = 0; i < 2; i++) begin
            tick(o);
            checks++;
            if (o !== obs_t'(0)) begin
                errors++;
                $display("[TB] FAIL cam_reset_hold cycle %0d: got %s, expected all zero", i, fmt(o));
            end
        end
        cam_reset_n = 1'b1;
        test_single_frame(0, "after_cam_reset");
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        pattern     = 2'($urandom_range(0, 3));
        cam_trigger = 1'b1;
        build_frame(pattern, 1);
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            tick(o);
            if (i == 0) cam_trigger = 1'b0;
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL async_prefix cycle %0d: got %s, expected %s", i, fmt(o), fmt(e));
            end
        end
        exp_q.delete();
        #2 reset_n = 1'b0;
        #1 o = sample_now();
        model_fc = 16'd0;
        checks++;
        if (o !== obs_t'(0)) begin
            errors++;
            $display("[TB] FAIL async_reset_immediate: got %s, expected all zero", fmt(o));
        end
        tick(o);
        reset_n = 1'b1;
        tick(o);
        checks++;
        if (o !== obs_t'(0)) begin
            errors++;
            $display("[TB] FAIL async_reset_release: got %s, expected all zero", fmt(o));
        end
    endtask

    task automatic test_wrap();
        obs_t o;
        @(negedge clk);
        force dut.frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count;
        tick(o);
        model_fc = 16'hFFFF;
        checks++;
        if (o.fc !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL wrap_preload: got fc=%0d, expected 65535", o.fc);
        end
        test_single_frame($urandom_range(0, 3), "wrap_frame");
    endtask

    task automatic test_random_frames();
        obs_t o, e;
        for (int f = 0; f < 4; f++) begin
            int gap = $urandom_range(0, 3);
            int p   = $urandom_range(0, 3);
            int i   = 0;
            for (int g = 0; g < gap; g++) begin
                tick(o);
                checks++;
                if (o !== obs_t'({3'b000, {DW{1'b0}}, model_fc})) begin
                    errors++;
                    $display("[TB] FAIL random_idle frame %0d: got %s", f, fmt(o));
                end
            end
            pattern     = 2'(p);
            cam_trigger = 1'b1;
            build_frame(p, 1);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tick(o);
                // Mid-frame triggers and pattern changes must be ignored.
                if (i >= 1 && i <= 10) begin
                    cam_trigger = 1'($urandom_range(0, 1));
                    pattern     = 2'($urandom_range(0, 3));
                end
                if (i == 0 || i == 11) cam_trigger = 1'b0;
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL random frame %0d cycle %0d: got %s, expected %s",
                             f, i, fmt(o), fmt(e));
                end
                i++;
            end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        cam_reset_n = 1'b1;
        cam_trigger = 1'b0;
        continuous  = 1'b0;
        pattern     = 2'd0;
        test_reset();
        test_single_frame(0, "single_p0");
        test_single_frame(2, "single_p2");
        test_continuous();
        test_pattern_change();
        test_cam_reset();
        test_async_reset();
        test_wrap();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
